chip8_timer_bank: RTL and testbench

Parametrised bank of CHIP-8 countdown timers (delay and sound, extensible to N channels). It replaces the single free-running blink/pulse counter in the top level with a prescaled tick generator, per-channel loadable down-counters and expiry flags. An optional square-wave tone output is driven while the sound channel is non-zero. It sits between `chip8_cpu` (load/read) and board outputs (LED, buzzer).

---
 rtl/chip8_pkg.sv | 13 +
 rtl/chip8_timer_bank_if.sv | 20 ++
 rtl/chip8_prescaler.sv | 31 +++
 rtl/chip8_timer_bank.sv | 108 ++++++++++
 tb/tb_chip8_timer_bank.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chip8_pkg.sv
// Shared constants and width helper for the CHIP-8 timer bank.
package chip8_pkg;

  localparam int unsigned TIMER_DELAY    = 0;
  localparam int unsigned TIMER_SOUND    = 1;
  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

  // Bits needed to index n items (never less than one bit).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chip8_timer_bank_if.sv
// CPU-side load/read port of the timer bank.
interface chip8_timer_bank_if
  import chip8_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8
);

  localparam int unsigned SW = sel_width(CHANNELS);

  logic             wr_en;
  logic [SW-1:0]    wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic [SW-1:0]    rd_sel;
  logic [WIDTH-1:0] rd_data;

  modport master (output wr_en, output wr_sel, output wr_data, output rd_sel, input rd_data);
  modport slave  (input wr_en, input wr_sel, input wr_data, input rd_sel, output rd_data);

endinterface

// File: rtl/chip8_prescaler.sv
// Free-running modulo-DIV counter; strobe marks the last count of each period.
module chip8_prescaler
  import chip8_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic strobe
);

  localparam int unsigned   CW   = sel_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] pcnt;

  assign strobe = (pcnt == LAST);

  // Count 0..DIV-1 and wrap; clr holds the counter at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (clr || strobe) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CW'(1);
    end
  end

endmodule

// File: rtl/chip8_timer_bank.sv
// Bank of CHIP-8 countdown timers with a shared prescaled tick.
// Optional square-wave tone on channel TONE_CH when CHIP8_TIMER_TONE_EN is defined;
// otherwise the tone port is tied low.
module chip8_timer_bank
  import chip8_pkg::*;
#(
  parameter int unsigned CLK_HZ   = CLK_HZ_DEFAULT,
  parameter int unsigned TICK_HZ  = 60,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TONE_CH  = TIMER_SOUND,
  parameter int unsigned TONE_HZ  = 440
) (
  input  logic                clk,
  input  logic                reset,
  chip8_timer_bank_if.slave   bus,
  output logic                tick,
  output logic [CHANNELS-1:0] active,
  output logic [CHANNELS-1:0] expired,
  output logic                tone
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SW  = sel_width(CHANNELS);

  localparam bit CFG_OK = (DIV >= 2) && (CHANNELS >= 1) && (CHANNELS <= 8) &&
                          (TONE_CH < CHANNELS) && (TONE_HZ != 0) &&
                          (CLK_HZ >= 2 * TONE_HZ);

  // An illegal parameter set shows up as this named block in the hierarchy.
  if (!CFG_OK) begin : g_illegal_parameters
  end

  logic                 strobe;
  logic [WIDTH-1:0]     timer_q [CHANNELS];
  logic [CHANNELS-1:0]  wr_hit;
  logic [WIDTH-1:0]     rd_mux;
  logic [WIDTH-1:0]     rd_q;

  chip8_prescaler #(.DIV(DIV)) u_tick_pre (
    .clk    (clk),
    .reset  (reset),
    .clr    (1'b0),
    .strobe (strobe)
  );

  // Write decode, read mux and non-zero flags; out-of-range selects match nothing.
  always_comb begin
    wr_hit = '0;
    rd_mux = '0;
    active = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = bus.wr_en && (bus.wr_sel == SW'(i));
      if (bus.rd_sel == SW'(i)) rd_mux = timer_q[i];
      active[i] = (timer_q[i] != '0);
    end
  end

  // Timers: a load beats the same-edge decrement; zero saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) timer_q[i] <= '0;
      expired <= '0;
      tick    <= 1'b0;
      rd_q    <= '0;
    end else begin
      tick <= strobe;
      rd_q <= rd_mux;
      for (int i = 0; i < CHANNELS; i++) begin
        expired[i] <= strobe && !wr_hit[i] && (timer_q[i] == WIDTH'(1));
        if (wr_hit[i]) begin
          timer_q[i] <= bus.wr_data;
        end else if (strobe && (timer_q[i] != '0)) begin
          timer_q[i] <= timer_q[i] - WIDTH'(1);
        end
      end
    end
  end

  assign bus.rd_data = rd_q;

`ifdef CHIP8_TIMER_TONE_EN
  localparam int unsigned TDIV = CLK_HZ / (2 * TONE_HZ);

  logic tone_strobe;

  chip8_prescaler #(.DIV(TDIV)) u_tone_pre (
    .clk    (clk),
    .reset  (reset),
    .clr    (!active[TONE_CH]),
    .strobe (tone_strobe)
  );

  // Square wave while the tone channel is non-zero, forced low otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tone <= 1'b0;
    end else if (!active[TONE_CH]) begin
      tone <= 1'b0;
    end else if (tone_strobe) begin
      tone <= ~tone;
    end
  end
`else
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_timer_bank.sv
// Scoreboard bench for chip8_timer_bank (CLK_HZ=600, TICK_HZ=60, TONE_HZ=100).
// Tone expectations follow CHIP8_TIMER_TONE_EN.
module tb_chip8_timer_bank;

  localparam int unsigned DIV  = 10;
  localparam int unsigned TDIV = 3;
`ifdef CHIP8_TIMER_TONE_EN
  localparam bit TONE_ON = 1'b1;
`else
  localparam bit TONE_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] rd;
    logic       tick;
    logic [1:0] act;
    logic [1:0] exp;
    logic       tone;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       tick, tone, tick3, tone3;
  logic [1:0] active, expired;
  logic [2:0] active3, expired3;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t        sb[$];
  int unsigned m_pcnt, m_tcnt;
  logic [7:0]  m_t[2];
  logic        m_tone;

  chip8_timer_bank_if #(.CHANNELS(2), .WIDTH(8)) bus ();
  chip8_timer_bank_if #(.CHANNELS(3), .WIDTH(8)) bus3 ();

  chip8_timer_bank #(.CLK_HZ(600), .TICK_HZ(60), .CHANNELS(2), .WIDTH(8),
                     .TONE_CH(1), .TONE_HZ(100)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .tick(tick), .active(active), .expired(expired), .tone(tone)
  );

  chip8_timer_bank #(.CLK_HZ(600), .TICK_HZ(60), .CHANNELS(3), .WIDTH(8),
                     .TONE_CH(1), .TONE_HZ(100)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .tick(tick3), .active(active3), .expired(expired3), .tone(tone3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  // Reference behaviour for one rising edge with the given inputs.
  task automatic model_edge(input logic we, input logic sel, input logic [7:0] d, input logic rs);
    obs_t       e;
    logic       s, hit;
    logic [7:0] nt[2];
    s      = (m_pcnt == DIV - 1);
    e.rd   = m_t[rs];
    e.tick = s;
    for (int c = 0; c < 2; c++) begin
      hit      = we && (int'(sel) == c);
      e.exp[c] = s && !hit && (m_t[c] == 8'd1);
      if (hit)                    nt[c] = d;
      else if (s && m_t[c] != 0)  nt[c] = m_t[c] - 8'd1;
      else                        nt[c] = m_t[c];
    end
    if (TONE_ON) begin
      if (m_t[1] == 8'd0) begin
        m_tcnt = 0;
        m_tone = 1'b0;
      end else if (m_tcnt == TDIV - 1) begin
        m_tcnt = 0;
        m_tone = ~m_tone;
      end else begin
        m_tcnt++;
      end
    end
    e.tone = m_tone;
    m_pcnt = s ? 0 : m_pcnt + 1;
    m_t[0] = nt[0];
    m_t[1] = nt[1];
    e.act  = {nt[1] != 8'd0, nt[0] != 8'd0};
    sb.push_back(e);
  endtask

  // Drive one cycle at the falling edge, then score the DUT after the rising edge.
  task automatic cycle(input logic we, input logic sel, input logic [7:0] d, input logic rs);
    obs_t o;
    bus.wr_en   = we;
    bus.wr_sel  = sel;
    bus.wr_data = d;
    bus.rd_sel  = rs;
    model_edge(we, sel, d, rs);
    @(posedge clk);
    @(negedge clk);
    o = sb.pop_front();
    check("rd_data", 32'(bus.rd_data), 32'(o.rd));
    check("tick",    32'(tick),        32'(o.tick));
    check("active",  32'(active),      32'(o.act));
    check("expired", 32'(expired),     32'(o.exp));
    check("tone",    32'(tone),        32'(o.tone));
  endtask

  task automatic idle(input logic rs);
    cycle(1'b0, 1'b0, 8'd0, rs);
  endtask

  // Assert reset between clock edges, verify immediate clearing, release on a falling edge.
  task automatic do_reset(input string tag);
    bus.wr_en  = 1'b0;
    bus3.wr_en = 1'b0;
    reset = 1'b0;
    #1;
    check({tag, "_rd"},      32'(bus.rd_data), 32'd0);
    check({tag, "_tick"},    32'(tick),        32'd0);
    check({tag, "_active"},  32'(active),      32'd0);
    check({tag, "_expired"}, 32'(expired),     32'd0);
    check({tag, "_tone"},    32'(tone),        32'd0);
    m_pcnt = 0;
    m_tcnt = 0;
    m_tone = 1'b0;
    m_t[0] = 8'd0;
    m_t[1] = 8'd0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int   nst, n_exp0;
    logic prev_tick;

    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_sel   = '0;
    bus.wr_data  = '0;
    bus.rd_sel   = '0;
    bus3.wr_en   = 1'b0;
    bus3.wr_sel  = '0;
    bus3.wr_data = '0;
    bus3.rd_sel  = '0;
    @(negedge clk);
    do_reset("por");

    // Idle: tick every DIV cycles, nothing else moves.
    for (int k = 1; k <= 30; k++) begin
      idle(1'b0);
      check("idle_tick", 32'(tick), 32'(k % 10 == 0));
    end

    // Countdown 3 -> 0 with a single expiry pulse.
    cycle(1'b1, 1'b0, 8'd3, 1'b0);
    check("load_active0", 32'(active[0]), 32'd1);
    nst = 0;
    n_exp0 = 0;
    prev_tick = 1'b0;
    for (int k = 0; k < 35; k++) begin
      idle(1'b0);
      if (prev_tick) check("ch0_step", 32'(bus.rd_data), 32'((nst >= 3) ? 0 : 3 - nst));
      if (tick) nst++;
      prev_tick = tick;
      if (expired[0]) n_exp0++;
    end
    check("exp0_pulses", 32'(n_exp0), 32'd1);
    check("ch0_done", 32'(active[0]), 32'd0);

    // Same-edge write on a strobe: load wins, other channel decrements.
    for (int g = 0; g < 20 && m_pcnt != 5; g++) idle(1'b0);
    cycle(1'b1, 1'b0, 8'd2, 1'b0);
    for (int g = 0; g < 20 && m_pcnt != DIV - 1; g++) idle(1'b0);
    cycle(1'b1, 1'b1, 8'd5, 1'b1);
    check("strobe_edge_tick", 32'(tick), 32'd1);
    idle(1'b1);
    check("same_edge_ch1", 32'(bus.rd_data), 32'd5);
    idle(1'b0);
    check("same_edge_ch0", 32'(bus.rd_data), 32'd1);

    // Writing 0 over a 1 never produces an expiry pulse.
    n_exp0 = 0;
    cycle(1'b1, 1'b0, 8'd0, 1'b0);
    check("clear_active0", 32'(active[0]), 32'd0);
    if (expired[0]) n_exp0++;
    for (int k = 0; k < 12; k++) begin
      idle(1'b0);
      if (expired[0]) n_exp0++;
    end
    check("clear_no_exp0", 32'(n_exp0), 32'd0);

    // Tone while ch1 is non-zero.
    cycle(1'b1, 1'b1, 8'd0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b1, 8'd2, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      idle(1'b1);
      if (k == 3) check("tone_first", 32'(tone), 32'(TONE_ON));
      if (k == 6) check("tone_second", 32'(tone), 32'd0);
    end
    for (int g = 0; g < 40 && m_t[1] != 8'd0; g++) idle(1'b1);
    idle(1'b1);
    check("tone_off", 32'(tone), 32'd0);
    check("ch1_done", 32'(active[1]), 32'd0);

    // Mid-count reset with ch0=200 and the prescaler at 7.
    do_reset("rst2");
    cycle(1'b1, 1'b0, 8'd200, 1'b0);
    for (int g = 0; g < 20 && m_pcnt != 7; g++) idle(1'b0);
    check("pre_rst_rd", 32'(bus.rd_data), 32'd200);
    do_reset("midrst");

    // First tick DIV cycles after release; out-of-range access on the 3-channel bank.
    for (int k = 1; k <= 10; k++) begin
      bus3.wr_en   = (k <= 2);
      bus3.wr_sel  = (k == 1) ? 2'd3 : 2'd2;
      bus3.wr_data = (k == 1) ? 8'd9 : 8'd7;
      bus3.rd_sel  = (k == 4) ? 2'd3 : 2'd2;
      idle(1'b0);
      check("post_rst_tick", 32'(tick), 32'(k == 10));
      check("tick3", 32'(tick3), 32'(k == 10));
      if (k == 3) check("rd3_ch2", 32'(bus3.rd_data), 32'd7);
      if (k == 4) begin
        check("rd3_oob", 32'(bus3.rd_data), 32'd0);
        check("active3", 32'(active3), 32'b100);
      end
    end
    bus3.wr_en = 1'b0;
    check("expired3", 32'(expired3), 32'd0);
    check("tone3", 32'(tone3), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
